// File: rtl/fp16_mult_lanes.sv
// rtl/fp16_mult_lanes.sv - LANES-wide 3-stage pipelined IEEE binary16 multiplier with tag/last sideband
//
// Purpose: multiplies LANES independent binary16 operand pairs per beat.
//          Subnormal inputs are flushed to zero and underflowing results
//          flush to zero. Rounding is round-to-nearest-even.
//          Pipeline: S1 decode + 11x11 multiply, S2 normalise + round,
//          S3 pack + output register. A single global stall freezes every stage.
//
// Ports:
//   clk, rst_n           clock; asynchronous active-low reset
//   s_valid/s_ready      input beat handshake
//   s_a, s_b             operands, lane i at bits [16i+15:16i]
//   s_neg                negate every non-NaN product of the beat
//   s_tag, s_last        per-beat sideband, passed through unchanged
//   m_valid/m_ready      result beat handshake
//   m_result             products, same lane packing as s_a
//   m_tag, m_last        sideband of the beat on m_result
module fp16_mult_lanes #(
    parameter int LANES = 4,
    parameter int TAG_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [16*LANES-1:0]   s_a,
    input  logic [16*LANES-1:0]   s_b,
    input  logic                  s_neg,
    input  logic [TAG_W-1:0]      s_tag,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [16*LANES-1:0]   m_result,
    output logic [TAG_W-1:0]      m_tag,
    output logic                  m_last
);

    logic                w_stall;
    logic                w_adv;
    logic                r_v1;
    logic                r_v2;
    logic                r_v3;
    logic [TAG_W-1:0]    r_tag1;
    logic [TAG_W-1:0]    r_tag2;
    logic [TAG_W-1:0]    r_tag3;
    logic                r_last1;
    logic                r_last2;
    logic                r_last3;
    logic [16*LANES-1:0] w_pack;
    logic [16*LANES-1:0] r_result;

    // The whole pipeline moves together; only a held output beat blocks it.
    assign w_stall  = r_v3 & ~m_ready;
    assign w_adv    = ~w_stall;
    assign s_ready  = w_adv;
    assign m_valid  = r_v3;
    assign m_result = r_result;
    assign m_tag    = r_tag3;
    assign m_last   = r_last3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1 <= 1'b0;
            r_v2 <= 1'b0;
            r_v3 <= 1'b0;
        end else if (w_adv) begin
            r_v1 <= s_valid;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
        end
    end

    always_ff @(posedge clk) begin
        if (w_adv) begin
            r_tag1  <= s_tag;
            r_last1 <= s_last;
            r_tag2  <= r_tag1;
            r_last2 <= r_last1;
        end
    end

    // Output registers only load real beats, so bubbles leave the last result in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result <= '0;
            r_tag3   <= '0;
            r_last3  <= 1'b0;
        end else if (w_adv && r_v2) begin
            r_result <= w_pack;
            r_tag3   <= r_tag2;
            r_last3  <= r_last2;
        end
    end

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        // S1: decode and multiply
        logic              w_sa;
        logic              w_sb;
        logic [4:0]        w_ea;
        logic [4:0]        w_eb;
        logic [9:0]        w_ma;
        logic [9:0]        w_mb;
        logic              w_a_zero;
        logic              w_b_zero;
        logic              w_a_inf;
        logic              w_b_inf;
        logic              w_a_nan;
        logic              w_b_nan;
        logic              w_nan;
        logic              w_inf;
        logic              w_zero;
        logic [21:0]       w_prod;
        logic signed [7:0] w_exp;

        logic [21:0]       r1_prod;
        logic signed [7:0] r1_exp;
        logic              r1_sign;
        logic              r1_nan;
        logic              r1_inf;
        logic              r1_zero;

        assign {w_sa, w_ea, w_ma} = s_a[16*gi +: 16];
        assign {w_sb, w_eb, w_mb} = s_b[16*gi +: 16];

        // exp==0 covers both true zero and subnormals, which are flushed.
        assign w_a_zero = (w_ea == 5'd0);
        assign w_b_zero = (w_eb == 5'd0);
        assign w_a_inf  = (w_ea == 5'd31) && (w_ma == 10'd0);
        assign w_b_inf  = (w_eb == 5'd31) && (w_mb == 10'd0);
        assign w_a_nan  = (w_ea == 5'd31) && (w_ma != 10'd0);
        assign w_b_nan  = (w_eb == 5'd31) && (w_mb != 10'd0);

        assign w_nan  = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
        assign w_inf  = (w_a_inf | w_b_inf) & ~w_nan;
        assign w_zero = (w_a_zero | w_b_zero) & ~w_nan & ~w_inf;

        assign w_prod = {11'd0, 1'b1, w_ma} * {11'd0, 1'b1, w_mb};
        // Biased exponent of the product assuming the significand product is in [1,2).
        assign w_exp  = $signed({3'b000, w_ea}) + $signed({3'b000, w_eb}) - 8'sd15;

        always_ff @(posedge clk) begin
            if (w_adv) begin
                r1_prod <= w_prod;
                r1_exp  <= w_exp;
                r1_sign <= w_sa ^ w_sb ^ s_neg;
                r1_nan  <= w_nan;
                r1_inf  <= w_inf;
                r1_zero <= w_zero;
            end
        end

        // S2: normalise and round
        logic              w_hi;
        logic [9:0]        w_mant;
        logic              w_guard;
        logic              w_sticky;
        logic              w_inc;
        logic [10:0]       w_rnd;
        logic signed [7:0] w_exp2;

        logic signed [7:0] r2_exp;
        logic [9:0]        r2_mant;
        logic              r2_sign;
        logic              r2_nan;
        logic              r2_inf;
        logic              r2_zero;

        // Significand product is in [1,4); bit 21 set means it reached [2,4).
        assign w_hi     = r1_prod[21];
        assign w_mant   = w_hi ? r1_prod[20:11] : r1_prod[19:10];
        assign w_guard  = w_hi ? r1_prod[10]    : r1_prod[9];
        assign w_sticky = w_hi ? (|r1_prod[9:0]) : (|r1_prod[8:0]);
        assign w_inc    = w_guard & (w_sticky | w_mant[0]);
        assign w_rnd    = {1'b0, w_mant} + {10'd0, w_inc};
        // A carry out of the rounded mantissa leaves its low bits zero and bumps the exponent.
        assign w_exp2   = r1_exp + $signed({7'd0, w_hi}) + $signed({7'd0, w_rnd[10]});

        always_ff @(posedge clk) begin
            if (w_adv) begin
                r2_exp  <= w_exp2;
                r2_mant <= w_rnd[9:0];
                r2_sign <= r1_sign;
                r2_nan  <= r1_nan;
                r2_inf  <= r1_inf;
                r2_zero <= r1_zero;
            end
        end

        // S3: pack, with overflow to infinity and flush-to-zero on underflow
        logic [15:0] w_res;

        always_comb begin
            w_res = {r2_sign, r2_exp[4:0], r2_mant};
            if (r2_nan) begin
                w_res = 16'h7E00;
            end else if (r2_inf || (r2_exp > 8'sd30)) begin
                w_res = {r2_sign, 15'h7C00};
            end else if (r2_zero || (r2_exp < 8'sd1)) begin
                w_res = {r2_sign, 15'h0000};
            end
        end

        assign w_pack[16*gi +: 16] = w_res;
    end

endmodule

// File: tb/tb_fp16_mult_lanes.sv
// tb/tb_fp16_mult_lanes.sv - directed self-checking bench for fp16_mult_lanes
module tb_fp16_mult_lanes;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        s_valid;
    logic        s_ready;
    logic [63:0] s_a;
    logic [63:0] s_b;
    logic        s_neg;
    logic [7:0]  s_tag;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [63:0] m_result;
    logic [7:0]  m_tag;
    logic        m_last;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fp16_mult_lanes #(.LANES(4), .TAG_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_a      (s_a),
        .s_b      (s_b),
        .s_neg    (s_neg),
        .s_tag    (s_tag),
        .s_last   (s_last),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_result (m_result),
        .m_tag    (m_tag),
        .m_last   (m_last)
    );

    // Drives one beat with m_ready high and waits (bounded) for its result.
    task automatic run_beat(input logic [63:0] a, input logic [63:0] b, input logic neg,
                            input logic [7:0] tag, input logic last,
                            output logic [63:0] res, output logic [7:0] tag_o,
                            output logic last_o, output int lat);
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_a     = a;
        s_b     = b;
        s_neg   = neg;
        s_tag   = tag;
        s_last  = last;
        @(negedge clk);
        s_valid = 1'b0;
        lat = 1;
        while (m_valid !== 1'b1 && lat < 10) begin
            @(negedge clk);
            lat++;
        end
        res    = m_result;
        tag_o  = m_tag;
        last_o = m_last;
    endtask

    function automatic logic [63:0] b2b_a(input int k);
        return (k % 2 == 1) ? {4{16'hBC00}} : {4{16'h3C00}};
    endfunction

    function automatic logic [63:0] b2b_b(input int k);
        logic [63:0] v;
        for (int j = 0; j < 4; j++) v[16*j +: 16] = 16'h4000 + 16'(k * 16 + j);
        return v;
    endfunction

    function automatic logic [63:0] b2b_exp(input int k);
        logic [63:0] v;
        logic        flip;
        flip = (k % 2 == 1) ^ (k % 3 == 0);
        v = b2b_b(k);
        for (int j = 0; j < 4; j++) v[16*j + 15] = v[16*j + 15] ^ flip;
        return v;
    endfunction

    task automatic test_reset();
        s_valid = 1'b0;
        m_ready = 1'b1;
        s_a = '0;
        s_b = '0;
        s_neg = 1'b0;
        s_tag = '0;
        s_last = 1'b0;
        #2 rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
        checks++;
        if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
        checks++;
        if (m_result !== 64'd0 || m_tag !== 8'd0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs got=%h/%h/%b exp=0/0/0", m_result, m_tag, m_last);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [63:0] res;
        logic [7:0]  tg;
        logic        ls;
        int          lat;
        run_beat({4{16'h3C00}}, {4{16'h4000}}, 1'b0, 8'h5A, 1'b1, res, tg, ls, lat);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL basic_latency got=%0d exp=3", lat); end
        checks++;
        if (res !== {4{16'h4000}}) begin failures++; $display("FAIL basic_result got=%h exp=%h", res, {4{16'h4000}}); end
        checks++;
        if (tg !== 8'h5A || ls !== 1'b1) begin failures++; $display("FAIL basic_sideband got=%h/%b exp=5a/1", tg, ls); end
        @(negedge clk);
        checks++;
        if (m_valid !== 1'b0) begin failures++; $display("FAIL basic_no_duplicate got=%b exp=0", m_valid); end
    endtask

    task automatic test_special();
        logic [63:0] res;
        logic [7:0]  tg;
        logic        ls;
        int          lat;
        run_beat({16'h7C00, 16'h7C00, 16'h7BFF, 16'h4200},
                 {16'h3C00, 16'h0000, 16'h4000, 16'h4500}, 1'b0, 8'h11, 1'b0, res, tg, ls, lat);
        checks++;
        if (lat != 3 || res !== {16'h7C00, 16'h7E00, 16'h7C00, 16'h4B80}) begin
            failures++;
            $display("FAIL special_pos got=%h lat=%0d exp=7c007e007c004b80 lat=3", res, lat);
        end
        run_beat({16'h0000, 16'h7BFF, 16'h7C00, 16'h4200},
                 {16'h3C00, 16'h4000, 16'h0000, 16'h4500}, 1'b1, 8'h22, 1'b1, res, tg, ls, lat);
        checks++;
        if (lat != 3 || res !== {16'h8000, 16'hFC00, 16'h7E00, 16'hCB80}) begin
            failures++;
            $display("FAIL special_neg got=%h lat=%0d exp=8000fc007e00cb80 lat=3", res, lat);
        end
        checks++;
        if (tg !== 8'h22 || ls !== 1'b1) begin failures++; $display("FAIL special_sideband got=%h/%b exp=22/1", tg, ls); end
    endtask

    task automatic test_round();
        logic [63:0] res;
        logic [7:0]  tg;
        logic        ls;
        int          lat;
        run_beat({16'h3C01, 16'h8000, 16'h0001, 16'h0400},
                 {16'h3C01, 16'h3C00, 16'h3C00, 16'h0400}, 1'b0, 8'h33, 1'b0, res, tg, ls, lat);
        checks++;
        if (res !== {16'h3C02, 16'h8000, 16'h0000, 16'h0000}) begin
            failures++;
            $display("FAIL round_flush got=%h exp=3c02800000000000", res);
        end
        run_beat({16'h3C03, 16'h3C01, 16'h3C01, 16'h3FFF},
                 {16'h3E00, 16'h3E00, 16'h3BFE, 16'h3FFF}, 1'b0, 8'h44, 1'b0, res, tg, ls, lat);
        checks++;
        if (res !== {16'h3E04, 16'h3E02, 16'h3C00, 16'h43FE}) begin
            failures++;
            $display("FAIL round_even_carry got=%h exp=3e043e023c0043fe", res);
        end
        run_beat({16'h0400, 16'h0400, 16'h7BFF, 16'h5C00},
                 {16'h3BFF, 16'h3C00, 16'h3C00, 16'h5C00}, 1'b0, 8'h55, 1'b0, res, tg, ls, lat);
        checks++;
        if (res !== {16'h0000, 16'h0400, 16'h7BFF, 16'h7C00}) begin
            failures++;
            $display("FAIL round_range_edges got=%h exp=000004007bff7c00", res);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] pat;
        logic [63:0] hold_res;
        logic [7:0]  hold_tag;
        logic        hold_last;
        logic        prev_stall;
        int          tx;
        int          rx;
        int          cyc;
        pat = 32'hB2E5_9C6B;
        prev_stall = 1'b0;
        hold_res = '0;
        hold_tag = '0;
        hold_last = 1'b0;
        tx = 0;
        rx = 0;
        cyc = 0;
        while (rx < 10 && cyc < 200) begin
            @(negedge clk);
            if (prev_stall) begin
                checks++;
                if (m_valid !== 1'b1 || m_result !== hold_res || m_tag !== hold_tag || m_last !== hold_last) begin
                    failures++;
                    $display("FAIL b2b_stall_hold cyc=%0d got=%b/%h/%h/%b exp=1/%h/%h/%b",
                             cyc, m_valid, m_result, m_tag, m_last, hold_res, hold_tag, hold_last);
                end
            end
            m_ready = pat[cyc % 32];
            if (tx < 10) begin
                s_valid = 1'b1;
                s_a     = b2b_a(tx);
                s_b     = b2b_b(tx);
                s_neg   = (tx % 3 == 0);
                s_tag   = 8'hA0 + 8'(tx);
                s_last  = (tx == 9);
            end else begin
                s_valid = 1'b0;
            end
            #1;
            checks++;
            if (s_ready !== ~(m_valid & ~m_ready)) begin
                failures++;
                $display("FAIL b2b_s_ready cyc=%0d got=%b exp=%b", cyc, s_ready, ~(m_valid & ~m_ready));
            end
            if (m_valid && m_ready) begin
                checks++;
                if (m_result !== b2b_exp(rx) || m_tag !== 8'hA0 + 8'(rx) || m_last !== (rx == 9)) begin
                    failures++;
                    $display("FAIL b2b_beat%0d got=%h/%h/%b exp=%h/%h/%b", rx, m_result, m_tag, m_last,
                             b2b_exp(rx), 8'hA0 + 8'(rx), (rx == 9));
                end
                rx++;
            end
            if (s_valid && s_ready) tx++;
            prev_stall = m_valid & ~m_ready;
            hold_res   = m_result;
            hold_tag   = m_tag;
            hold_last  = m_last;
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        checks++;
        if (rx != 10) begin failures++; $display("FAIL b2b_count got=%0d exp=10", rx); end
    endtask

    task automatic test_reset_midflight();
        logic [63:0] res;
        logic [7:0]  tg;
        logic        ls;
        int          lat;
        @(negedge clk);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_a     = {4{16'h4200}};
        s_b     = {4{16'h4500}};
        s_neg   = 1'b0;
        s_last  = 1'b0;
        s_tag   = 8'h01;
        @(negedge clk);
        s_tag = 8'h02;
        @(negedge clk);
        s_tag = 8'h03;
        @(negedge clk);
        s_valid = 1'b0;
        checks++;
        if (m_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", m_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_async_drop got=%b/%b exp=0/1", m_valid, s_ready);
        end
        checks++;
        if (m_result !== 64'd0 || m_tag !== 8'd0 || m_last !== 1'b0) begin
            failures++;
            $display("FAIL mid_outputs_cleared got=%h/%h/%b exp=0/0/0", m_result, m_tag, m_last);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_beat cyc=%0d got=%b exp=0", i, m_valid); end
        end
        run_beat({4{16'h4200}}, {4{16'h4500}}, 1'b1, 8'h77, 1'b1, res, tg, ls, lat);
        checks++;
        if (lat != 3) begin failures++; $display("FAIL mid_post_latency got=%0d exp=3", lat); end
        checks++;
        if (res !== {4{16'hCB80}} || tg !== 8'h77 || ls !== 1'b1) begin
            failures++;
            $display("FAIL mid_post_result got=%h/%h/%b exp=%h/77/1", res, tg, ls, {4{16'hCB80}});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_special();
        test_round();
        test_back_to_back();
        test_reset_midflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fp16_mult_lanes.md
FP16_MULT_LANES -- requirements
Module: fp16_mult_lanes

Interface
REQ-001 Parameter LANES, default 4, number of parallel FP16 multiply lanes (1..16).
REQ-002 Parameter TAG_W, default 8, width of the sideband tag carried alongside each beat.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 s_valid  input  1  input beat valid.
REQ-006 s_ready  output  1  block can accept an input beat.
REQ-007 s_a  input  16*LANES  operand A, lane i at bits [16i+15:16i], IEEE binary16.
REQ-008 s_b  input  16*LANES  operand B, same packing as s_a.
REQ-009 s_neg  input  1  beat-wide negate-result mode (1 = return -(a*b)).
REQ-010 s_tag  input  TAG_W  sideband tag, passed through unmodified.
REQ-011 s_last  input  1  end-of-vector marker, passed through unmodified.
REQ-012 m_valid  output  1  result beat valid.
REQ-013 m_ready  input  1  downstream accepts result beat.
REQ-014 m_result  output  16*LANES  products, same packing as s_a.
REQ-015 m_tag  output  TAG_W  tag of the beat on m_result.
REQ-016 m_last  output  1  last flag of the beat on m_result.

Function
REQ-017 A transfer occurs on a side when valid and ready are both high at a rising edge; beats are never dropped, duplicated or reordered.
REQ-018 Datapath is a 3-stage pipeline: S1 unpack/special-case decode and 11x11 mantissa multiply, S2 normalise and round, S3 pack and output register.
REQ-019 Latency is exactly 3 cycles from input transfer to m_valid high when m_ready is held high.
REQ-020 Throughput is one beat per cycle when m_ready is held high.
REQ-021 Global stall: the pipeline advances only when stall = m_valid & ~m_ready is low; s_ready = ~stall.
REQ-022 While stalled, m_result, m_tag and m_last hold stable and m_valid stays high.
REQ-023 Empty stages (bubbles) carry valid=0; bubbles need not be collapsed during a stall.
REQ-024 m_valid is never asserted without a corresponding accepted input beat.
REQ-025 Each lane computes independently; s_neg, s_tag and s_last apply to the whole beat.
REQ-026 Result sign = sign(a) XOR sign(b) XOR s_neg for every non-NaN result.
REQ-027 Subnormal inputs (exp=0, mant!=0) are treated as signed zero.
REQ-028 Rounding is round-to-nearest-even on the 22-bit product, including a mantissa carry into the exponent after rounding.
REQ-029 Unbiased exponent after rounding > 15 -> signed infinity (0x7C00 / 0xFC00).
REQ-030 Unbiased exponent after rounding < -14 -> signed zero (flush-to-zero, no subnormal outputs).
REQ-031 Any NaN input, or infinity times zero, -> canonical NaN 0x7E00 (s_neg ignored).
REQ-032 Infinity times a finite non-zero value -> signed infinity; zero times a finite value -> signed zero.

Reset
REQ-033 While rst_n is low, all pipeline valid bits clear immediately; m_valid = 0, s_ready = 1.
REQ-034 On reset, m_result, m_tag and m_last are 0.
REQ-035 Reset asserted mid-operation discards all in-flight beats; the first beat after deassertion appears after exactly 3 cycles.
REQ-036 Data registers other than the outputs need no reset.

Verification
REQ-037 LANES=4, a=0x3C00 and b=0x4000 in all lanes, s_neg=0, tag=0x5A, last=1, m_ready=1 -> 3 cycles later all lanes = 0x4000, m_tag=0x5A, m_last=1.
REQ-038 Lane values 0x4200*0x4500, 0x4200*0x4500 with s_neg=1, 0x7BFF*0x4000, 0x7C00*0x0000 -> 0x4B80, 0xCB80, 0x7C00, 0x7E00.
REQ-039 Lane values 0x0400*0x0400, 0x0001*0x3C00, 0x8000*0x3C00, 0x3C01*0x3C01 -> 0x0000, 0x0000, 0x8000, 0x3C02 (round-to-nearest-even).
REQ-040 Back-to-back stream of 10 beats with m_ready toggling pseudo-randomly -> all 10 beats received in order, with stable outputs during every stall and s_ready = ~(m_valid & ~m_ready) every cycle.
REQ-041 rst_n pulsed low with 3 beats in flight -> m_valid drops asynchronously, no stale beat ever emerges, and a new beat after reset emerges in 3 cycles.
